paddle_sprite: RTL

- Parametrised, user-driven on-screen sprite for the VGA pipeline. Both axes are steered by buttons, with per-axis velocity ramping and border clamping.
- Position advances only on a once-per-frame tick. The block emits a registered per-pixel hit flag and colour to the pixel mux.
- Replaces the fixed 800x600, Y-only button widget.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/paddle_sprite_if.sv | 49 ++++
 rtl/axis_mover.sv | 146 ++++++++++++++
 rtl/paddle_sprite.sv | 116 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sprite pipeline: axis-state encoding,
// default screen geometry and colour channel width.
package vga_pkg;

    // Per-axis motion state; NEG moves toward 0, POS toward the far border.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        POS  = 2'd2
    } axis_state_t;

    localparam int DEFAULT_SCREEN_W = 800;
    localparam int DEFAULT_SCREEN_H = 600;
    localparam int COLOR_W          = 4;

    // Maps a pair of opposing buttons to the requested axis state.
    // Pressing both, or neither, requests IDLE.
    function automatic axis_state_t decode_dir(input logic neg, input logic pos);
        axis_state_t dir;
        if (neg && !pos) begin
            dir = NEG;
        end else if (pos && !neg) begin
            dir = POS;
        end else begin
            dir = IDLE;
        end
        return dir;
    endfunction

endpackage

// File: rtl/paddle_sprite_if.sv
// Signal bundle between the pixel pipeline and a paddle_sprite instance.
// The master side drives buttons, scan position and colour; the slave side
// (the sprite) returns the hit flag, registered colour and its position.
interface paddle_sprite_if #(
    parameter int COORD_W = 11,
    parameter int SIZE_W  = 9
);
    import vga_pkg::*;

    logic                frameTick;
    logic                enable;
    logic                up;
    logic                down;
    logic                left;
    logic                right;
    logic [COORD_W-1:0]  X;
    logic [COORD_W-1:0]  Y;
    logic [COORD_W-1:0]  firstX;
    logic [COORD_W-1:0]  firstY;
    logic [SIZE_W-1:0]   xSize;
    logic [SIZE_W-1:0]   ySize;
    logic [COLOR_W-1:0]  redIn;
    logic [COLOR_W-1:0]  greenIn;
    logic [COLOR_W-1:0]  blueIn;

    logic                yes;
    logic [COLOR_W-1:0]  red;
    logic [COLOR_W-1:0]  green;
    logic [COLOR_W-1:0]  blue;
    logic [COORD_W-1:0]  myX;
    logic [COORD_W-1:0]  myY;
    logic                moving;
    logic                edgeHit;

    modport master (
        output frameTick, enable, up, down, left, right,
        output X, Y, firstX, firstY, xSize, ySize,
        output redIn, greenIn, blueIn,
        input  yes, red, green, blue, myX, myY, moving, edgeHit
    );

    modport slave (
        input  frameTick, enable, up, down, left, right,
        input  X, Y, firstX, firstY, xSize, ySize,
        input  redIn, greenIn, blueIn,
        output yes, red, green, blue, myX, myY, moving, edgeHit
    );

endinterface

// File: rtl/axis_mover.sv
// One axis of sprite motion: direction FSM, speed ramp with hold counter,
// and border handling. Border rule is a clamp by default; defining
// PADDLE_WRAP_EN makes the axis wrap modulo the screen limit instead.
// Everything updates only when tick is high (frameTick && enable).
module axis_mover
    import vga_pkg::*;
#(
    parameter int COORD_W      = 11,
    parameter int SIZE_W       = 9,
    parameter int SPEED_W      = 5,
    parameter int MIN_SPEED    = 1,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               neg,
    input  logic               pos,
    input  logic [COORD_W-1:0] resetPos,
    input  logic [SIZE_W-1:0]  size,
    input  logic [COORD_W-1:0] screen,
    output logic [COORD_W-1:0] position,
    output axis_state_t        state,
    output logic               edgePulse
);

    // Two guard bits so sums and differences never wrap unnoticed.
    localparam int WIDE   = COORD_W + 2;
    localparam int HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [SPEED_W-1:0] MIN_SPD  = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] MAX_SPD  = SPEED_W'(MAX_SPEED);
    localparam logic [HOLD_W-1:0]  HOLD_TOP = HOLD_W'(ACCEL_FRAMES - 1);

    logic [SPEED_W-1:0] speed;
    logic [HOLD_W-1:0]  holdCnt;

    axis_state_t        nextState;
    logic [SPEED_W-1:0] nextSpeed;
    logic [HOLD_W-1:0]  nextHold;
    logic [SPEED_W-1:0] step;
    logic [COORD_W-1:0] nextPos;
    logic               nextEdge;

    logic [WIDE-1:0]    posW;
    logic [WIDE-1:0]    stepW;
    logic [WIDE-1:0]    sizeW;
    logic [WIDE-1:0]    screenW;

    assign posW    = {2'b00, position};
    assign stepW   = WIDE'(step);
    assign sizeW   = WIDE'(size);
    assign screenW = {2'b00, screen};

    // Next direction, speed ramp and border-corrected position for this tick.
    // A speed bump on the last frame of a hold window takes effect on that
    // same frame, so each speed lasts exactly ACCEL_FRAMES held frames.
    always_comb begin
        nextState = decode_dir(neg, pos);
        nextSpeed = speed;
        nextHold  = holdCnt;
        step      = '0;
        nextPos   = position;
        nextEdge  = 1'b0;

        if (nextState == IDLE) begin
            nextSpeed = MIN_SPD;
            nextHold  = '0;
        end else if (nextState == state) begin
            if (holdCnt == HOLD_TOP) begin
                nextHold  = '0;
                nextSpeed = (speed >= MAX_SPD) ? MAX_SPD : speed + SPEED_W'(1);
            end else begin
                nextHold  = holdCnt + HOLD_W'(1);
            end
            step = nextSpeed;
        end else begin
            nextSpeed = MIN_SPD;
            nextHold  = '0;
            step      = MIN_SPD;
        end

        unique case (nextState)
`ifdef PADDLE_WRAP_EN
            NEG: begin
                if (posW < stepW) begin
                    nextPos  = COORD_W'(posW + screenW - stepW);
                    nextEdge = 1'b1;
                end else begin
                    nextPos  = COORD_W'(posW - stepW);
                end
            end
            POS: begin
                if (posW + stepW >= screenW) begin
                    nextPos  = COORD_W'(posW + stepW - screenW);
                    nextEdge = 1'b1;
                end else begin
                    nextPos  = COORD_W'(posW + stepW);
                end
            end
`else
            NEG: begin
                if (posW < stepW) begin
                    nextPos  = '0;
                    nextEdge = 1'b1;
                end else begin
                    nextPos  = COORD_W'(posW - stepW);
                end
            end
            POS: begin
                if (posW + stepW + sizeW > screenW - WIDE'(1)) begin
                    nextPos  = COORD_W'(screenW - WIDE'(1) - sizeW);
                    nextEdge = 1'b1;
                end else begin
                    nextPos  = COORD_W'(posW + stepW);
                end
            end
`endif
            default: begin
                nextPos  = position;
                nextEdge = 1'b0;
            end
        endcase
    end

    // Commit motion state on update ticks; the edge pulse lasts one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position  <= resetPos;
            state     <= IDLE;
            speed     <= MIN_SPD;
            holdCnt   <= '0;
            edgePulse <= 1'b0;
        end else if (tick) begin
            position  <= nextPos;
            state     <= nextState;
            speed     <= nextSpeed;
            holdCnt   <= nextHold;
            edgePulse <= nextEdge;
        end else begin
            edgePulse <= 1'b0;
        end
    end

endmodule

// File: rtl/paddle_sprite.sv
// Button-steered sprite for the VGA pipeline. Two axis_mover instances move
// the sprite once per frame; this level registers the per-pixel hit flag and
// colour (one clock latency) and combines the per-axis status.
// Optional PADDLE_WRAP_EN switches both axes from border clamping to wrap.
module paddle_sprite
    import vga_pkg::*;
#(
    parameter int SCREEN_W     = DEFAULT_SCREEN_W,
    parameter int SCREEN_H     = DEFAULT_SCREEN_H,
    parameter int COORD_W      = 11,
    parameter int SIZE_W       = 9,
    parameter int SPEED_W      = 5,
    parameter int MIN_SPEED    = 1,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic          clk,
    input  logic          reset,
    paddle_sprite_if.slave bus
);

    localparam int WIDE = COORD_W + 2;

    logic               updateTick;
    logic [COORD_W-1:0] posX;
    logic [COORD_W-1:0] posY;
    axis_state_t        stateX;
    axis_state_t        stateY;
    logic               edgeX;
    logic               edgeY;
    logic               hit;
    logic               yesReg;
    logic [COLOR_W-1:0] redReg;
    logic [COLOR_W-1:0] greenReg;
    logic [COLOR_W-1:0] blueReg;

    assign updateTick = bus.frameTick && bus.enable;

    axis_mover #(
        .COORD_W      (COORD_W),
        .SIZE_W       (SIZE_W),
        .SPEED_W      (SPEED_W),
        .MIN_SPEED    (MIN_SPEED),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) xAxis (
        .clk       (clk),
        .reset     (reset),
        .tick      (updateTick),
        .neg       (bus.left),
        .pos       (bus.right),
        .resetPos  (bus.firstX),
        .size      (bus.xSize),
        .screen    (COORD_W'(SCREEN_W)),
        .position  (posX),
        .state     (stateX),
        .edgePulse (edgeX)
    );

    axis_mover #(
        .COORD_W      (COORD_W),
        .SIZE_W       (SIZE_W),
        .SPEED_W      (SPEED_W),
        .MIN_SPEED    (MIN_SPEED),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) yAxis (
        .clk       (clk),
        .reset     (reset),
        .tick      (updateTick),
        .neg       (bus.up),
        .pos       (bus.down),
        .resetPos  (bus.firstY),
        .size      (bus.ySize),
        .screen    (COORD_W'(SCREEN_H)),
        .position  (posY),
        .state     (stateY),
        .edgePulse (edgeY)
    );

    // Inclusive rectangle test against the current registered position,
    // evaluated with guard bits so myX+xSize cannot wrap.
    always_comb begin
        hit = ({2'b00, bus.X} >= {2'b00, posX}) &&
              ({2'b00, bus.X} <= {2'b00, posX} + WIDE'(bus.xSize)) &&
              ({2'b00, bus.Y} >= {2'b00, posY}) &&
              ({2'b00, bus.Y} <= {2'b00, posY} + WIDE'(bus.ySize));
    end

    // Register hit flag and colour together so downstream sees them aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            yesReg   <= 1'b0;
            redReg   <= '0;
            greenReg <= '0;
            blueReg  <= '0;
        end else begin
            yesReg   <= hit;
            redReg   <= bus.redIn;
            greenReg <= bus.greenIn;
            blueReg  <= bus.blueIn;
        end
    end

    // Status outputs are plain ORs of per-axis registers, so they change on
    // the same edge as the position they describe.
    assign bus.moving  = (stateX != IDLE) || (stateY != IDLE);
    assign bus.edgeHit = edgeX || edgeY;
    assign bus.myX     = posX;
    assign bus.myY     = posY;
    assign bus.yes     = yesReg;
    assign bus.red     = redReg;
    assign bus.green   = greenReg;
    assign bus.blue    = blueReg;

endmodule
